// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with load/use and mispredict hazard detection.
// A bubble (NOP, AOK, no registers) replaces the decode contents whenever a hazard or flush is requested.
module decode_execute_reg #(
   parameter int         W_DATA = 64,
   parameter int         W_CNT  = 16,
   parameter logic [3:0] RNONE  = 4'hF,
   parameter logic [3:0] I_NOP  = 4'h1,
   parameter logic [3:0] S_AOK  = 4'h1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        d_stat,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        D_ifun,
   input  logic [W_DATA-1:0] d_valC,
   input  logic [W_DATA-1:0] d_valA,
   input  logic [W_DATA-1:0] d_valB,
   input  logic [3:0]        d_dstE,
   input  logic [3:0]        d_dstM,
   input  logic [3:0]        d_srcA,
   input  logic [3:0]        d_srcB,
   input  logic              e_Cnd,
   input  logic              ext_bubble,
   output logic [3:0]        E_stat,
   output logic [3:0]        E_icode,
   output logic [3:0]        E_ifun,
   output logic [W_DATA-1:0] E_valC,
   output logic [W_DATA-1:0] E_valA,
   output logic [W_DATA-1:0] E_valB,
   output logic [3:0]        E_dstE,
   output logic [3:0]        E_dstM,
   output logic [3:0]        E_srcA,
   output logic [3:0]        E_srcB,
   output logic              load_use,
   output logic              mispredict,
   output logic [W_CNT-1:0]  bubble_cnt
);

   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] I_JXX    = 4'h7;

   logic e_bubble;

   always_comb begin
      // NOTE: both flags get a default first so no path leaves them unassigned (no latch).
      load_use   = 1'b0;
      mispredict = 1'b0;
      // RNONE guard also keeps a decode source of RNONE from ever matching.
      if ((E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != RNONE &&
          (E_dstM == d_srcA || E_dstM == d_srcB))
         load_use = 1'b1;
      if (E_icode == I_JXX && !e_Cnd)
         mispredict = 1'b1;
   end

   assign e_bubble = load_use | mispredict | ext_bubble;

   // NOTE: non-blocking assignments throughout; every field is reset because the
   // reset image must equal the bubble image seen by downstream stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         E_stat     <= S_AOK;
         E_icode    <= I_NOP;
         E_ifun     <= 4'h0;
         E_valC     <= '0;
         E_valA     <= '0;
         E_valB     <= '0;
         E_dstE     <= RNONE;
         E_dstM     <= RNONE;
         E_srcA     <= RNONE;
         E_srcB     <= RNONE;
         bubble_cnt <= '0;
      end else begin
         if (e_bubble) begin
            E_stat  <= S_AOK;
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
         end else begin
            E_stat  <= d_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= d_valC;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
         end
         // Saturate rather than wrap so long runs still report a meaningful lower bound.
         if (e_bubble && bubble_cnt != {W_CNT{1'b1}})
            bubble_cnt <= bubble_cnt + W_CNT'(1);
      end
   end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: a struct-level model of the E register checked
// every falling edge, plus literal expectations for the directed scenarios.
module tb_decode_execute_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  d_stat, D_icode, D_ifun;
   logic [63:0] d_valC, d_valA, d_valB;
   logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
   logic        e_Cnd, ext_bubble;
   logic [3:0]  E_stat, E_icode, E_ifun;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
   logic        load_use, mispredict;
   logic [15:0] bubble_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   decode_execute_reg dut (
      .clk(clk), .rst_n(rst_n), .d_stat(d_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .ext_bubble(ext_bubble),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
      .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .load_use(load_use), .mispredict(mispredict), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  stat, icode, ifun;
      logic [63:0] valC, valA, valB;
      logic [3:0]  dstE, dstM, srcA, srcB;
   } e_t;

   e_t m;
   int exp_cnt;

   function automatic e_t bubble_img();
      e_t b;
      b = '{4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF};
      return b;
   endfunction

   function automatic e_t decode_img();
      e_t d;
      d = '{d_stat, D_icode, D_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB};
      return d;
   endfunction

   function automatic logic exp_lu();
      return (m.icode == 4'h5 || m.icode == 4'hB) && m.dstM != 4'hF &&
             (m.dstM == d_srcA || m.dstM == d_srcB);
   endfunction

   function automatic logic exp_mp();
      return m.icode == 4'h7 && e_Cnd == 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m       = bubble_img();
         exp_cnt = 0;
      end else if (exp_lu() || exp_mp() || ext_bubble) begin
         m = bubble_img();
         if (exp_cnt < 65535) exp_cnt = exp_cnt + 1;
      end else begin
         m = decode_img();
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("m_stat", E_stat, m.stat);
      check("m_icode", E_icode, m.icode);
      check("m_ifun", E_ifun, m.ifun);
      check("m_valC", E_valC, m.valC);
      check("m_valA", E_valA, m.valA);
      check("m_valB", E_valB, m.valB);
      check("m_dstE", E_dstE, m.dstE);
      check("m_dstM", E_dstM, m.dstM);
      check("m_srcA", E_srcA, m.srcA);
      check("m_srcB", E_srcB, m.srcB);
      check("m_load_use", load_use, exp_lu());
      check("m_mispredict", mispredict, exp_mp());
      check("m_bubble_cnt", bubble_cnt, exp_cnt);
   end

   task automatic vec(input logic [3:0] stat, icode, ifun, input logic [63:0] c, a, b,
                      input logic [3:0] de, dm, sa, sb, input logic cnd, ext);
      d_stat = stat; D_icode = icode; D_ifun = ifun;
      d_valC = c; d_valA = a; d_valB = b;
      d_dstE = de; d_dstM = dm; d_srcA = sa; d_srcB = sb;
      e_Cnd = cnd; ext_bubble = ext;
   endtask

   // Advance one active edge and sample just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop_vec();
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h11, 64'h22, 4'h5, 4'hF, 4'h1, 4'h2, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vec(4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom));
         step();
      end
      check("rst_icode", E_icode, 64'h1);
      check("rst_dstE", E_dstE, 64'hF);
      check("rst_dstM", E_dstM, 64'hF);
      check("rst_valA", E_valA, 64'h0);
      check("rst_cnt", bubble_cnt, 64'h0);
      check("rst_lu", load_use, 64'h0);
      check("rst_mp", mispredict, 64'h0);

      // Pass-through: first edge after release loads decode
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h3, 4'hF, 4'h2, 4'h3, 1'b1, 1'b0);
      rst_n = 1'b1;
      step();
      check("pt_icode", E_icode, 64'h6);
      check("pt_valA", E_valA, 64'h5);
      check("pt_valB", E_valB, 64'h7);
      check("pt_dstE", E_dstE, 64'h3);
      check("pt_cnt", bubble_cnt, 64'h0);

      // Load/use on srcA
      vec(4'h1, 4'h5, 4'h0, 64'h8, 64'h0, 64'h0, 4'hF, 4'h4, 4'hF, 4'h2, 1'b1, 1'b0);
      step();
      check("lu_load_dstM", E_dstM, 64'h4);
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'h4, 4'hF, 1'b1, 1'b0);
      #1 check("lu_srcA", load_use, 64'h1);
      step();
      check("lu_bub_icode", E_icode, 64'h1);
      check("lu_bub_dstM", E_dstM, 64'hF);
      check("lu_bub_cnt", bubble_cnt, 64'h1);
      check("lu_no_retrigger", load_use, 64'h0);

      // Load/use with RNONE sources, then a srcB match
      vec(4'h1, 4'h5, 4'h0, 64'h8, 64'h0, 64'h0, 4'hF, 4'h4, 4'hF, 4'h2, 1'b1, 1'b0);
      step();
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
      #1 check("lu_rnone_src", load_use, 64'h0);
      d_srcB = 4'h4;
      #1 check("lu_srcB", load_use, 64'h1);
      d_srcB = 4'hF;
      step();
      check("lu_none_icode", E_icode, 64'h6);
      check("lu_none_cnt", bubble_cnt, 64'h1);

      // popq with real dstM, then popq with dstM=RNONE against RNONE sources
      vec(4'h1, 4'hB, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0);
      step();
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'hF, 4'h4, 1'b1, 1'b0);
      #1 check("pop_srcB", load_use, 64'h1);
      step();
      check("pop_cnt", bubble_cnt, 64'h2);
      vec(4'h1, 4'hB, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'hF, 4'h4, 4'h4, 1'b1, 1'b0);
      step();
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
      #1 check("pop_dstM_rnone", load_use, 64'h0);
      step();

      // Mispredict, not taken
      vec(4'h1, 4'h7, 4'h1, 64'h100, 64'h200, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
      step();
      check("jxx_icode", E_icode, 64'h7);
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h3, 64'h4, 4'h5, 4'hF, 4'h1, 4'h2, 1'b0, 1'b0);
      #1 check("mp_flag", mispredict, 64'h1);
      check("mp_lu_clear", load_use, 64'h0);
      step();
      check("mp_bub_icode", E_icode, 64'h1);
      check("mp_bub_cnt", bubble_cnt, 64'h3);

      // Jump taken: no bubble
      vec(4'h1, 4'h7, 4'h1, 64'h100, 64'h200, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
      step();
      vec(4'h1, 4'h6, 4'h0, 64'h0, 64'h9, 64'h4, 4'h5, 4'hF, 4'h1, 4'h2, 1'b1, 1'b0);
      #1 check("cnd_mp_clear", mispredict, 64'h0);
      step();
      check("cnd_icode", E_icode, 64'h6);
      check("cnd_valA", E_valA, 64'h9);
      check("cnd_cnt", bubble_cnt, 64'h3);

      // Exceptional status passes through; replaced only by a bubble
      vec(4'h4, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
      step();
      check("hlt_stat", E_stat, 64'h4);
      vec(4'h3, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
      step();
      check("ins_bub_stat", E_stat, 64'h1);
      check("ins_bub_cnt", bubble_cnt, 64'h4);

      // Async reset while bubbling with bubble_cnt=10
      for (int i = 0; i < 20 && exp_cnt != 10; i++) step();
      check("pre_rst_cnt", bubble_cnt, 64'd10);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cnt", bubble_cnt, 64'h0);
      check("arst_icode", E_icode, 64'h1);
      check("arst_dstM", E_dstM, 64'hF);
      step();
      nop_vec();
      rst_n = 1'b1;
      step();
      check("rel_icode", E_icode, 64'h6);
      #2 rst_n = 1'b0;
      #1;
      check("arst2_icode", E_icode, 64'h1);
      check("arst2_valA", E_valA, 64'h0);
      check("arst2_dstE", E_dstE, 64'hF);
      step();
      rst_n = 1'b1;

      // Counter saturation
      ext_bubble = 1'b1;
      repeat (65540) step();
      check("sat_cnt", bubble_cnt, 64'hFFFF);
      nop_vec();
      step();
      check("sat_hold_cnt", bubble_cnt, 64'hFFFF);
      check("sat_hold_icode", E_icode, 64'h6);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Pipeline register between the decode stage (forwarded operand selection) and the execute stage.
- Captures decode results every cycle.
- Contains the hazard detection that decides when E gets a bubble: load/use hazard and mispredicted jump.
- Exports those hazard flags combinationally so fetch/decode control can stall or bubble, and keeps a saturating bubble counter for performance checks.

Parameters:
- W_DATA, 64, width of valC/valA/valB
- W_CNT, 16, width of bubble counter
- RNONE, 4'hF, "no register" ID
- I_NOP, 4'h1, icode inserted by a bubble
- S_AOK, 4'h1, status inserted by a bubble

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- d_stat  in  4  status from decode
- D_icode  in  4  decode-stage icode
- D_ifun  in  4  decode-stage ifun
- d_valC  in  64  constant word
- d_valA  in  64  forwarded operand A (already includes valP for call/jXX)
- d_valB  in  64  forwarded operand B
- d_dstE, d_dstM, d_srcA, d_srcB  in  4 each  register IDs from decode
- e_Cnd  in  1  condition result of instruction currently in E
- ext_bubble  in  1  external bubble request (debug/exception flush)
- E_stat, E_icode, E_ifun  out  4 each  registered fields
- E_valC, E_valA, E_valB  out  64 each  registered values
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered IDs
- load_use  out  1  combinational load/use hazard flag
- mispredict  out  1  combinational mispredicted jXX flag
- bubble_cnt  out  16  saturating count of bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - E register holds the bubble value: E_stat=S_AOK, E_icode=I_NOP, E_ifun=0, E_valC/E_valA/E_valB=0, all four register IDs=RNONE.
  - bubble_cnt=0.
  - Release is synchronous to the next clk edge.
- load_use = (E_icode==4'h5 mrmovq || E_icode==4'hB popq) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - A source equal to RNONE never matches.
- mispredict = (E_icode==4'h7) && (e_Cnd==0).
- load_use and mispredict are mutually exclusive by icode; no priority between them is needed.
- E_bubble = load_use || mispredict || ext_bubble.
- Each rising clk edge:
  - If E_bubble=1, load the bubble value (same as the reset value).
  - Otherwise load all decode inputs unchanged: E_stat←d_stat, E_icode←D_icode, etc.
- The E register never stalls; a new value loads every cycle.
- Latency: decode inputs appear on E_* one cycle after being presented.
- bubble_cnt:
  - Increments by 1 on each edge where E_bubble=1.
  - Saturates at 16'hFFFF (no wrap).
  - Holds otherwise.
- A bubble moving through E must not re-trigger hazards: NOP icode matches neither condition.
- Exceptional d_stat (ADR/INS/HLT) is passed through untouched. It is replaced only when a bubble is inserted on that edge.
- Reset asserted mid-sequence overrides any pending bubble or load in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with random inputs and clock running → E_icode=1, E_dstE=E_dstM=F, E_valA=0, bubble_cnt=0, both flags 0. Deassert rst_n → first edge loads decode inputs.
- Pass-through: D_icode=6, D_ifun=0, d_valA=64'h5, d_valB=64'h7, d_dstE=3, d_srcA=2, d_srcB=3, no hazard → next edge E_icode=6, E_valA=5, E_valB=7, E_dstE=3; bubble_cnt unchanged.
- Load/use: E holds mrmovq with E_dstM=4; decode presents d_srcA=4 → load_use=1 in the same cycle; next edge E_icode=1, E_dstM=F, bubble_cnt+1. With d_srcA=d_srcB=F instead → load_use=0.
- Mispredict: E holds jXX, e_Cnd=0 → mispredict=1, next E is bubble. Same with e_Cnd=1 → mispredict=0, decode loaded normally.
- Counter saturation: force ext_bubble=1 for 65540 cycles → bubble_cnt stops at 16'hFFFF and stays there.
- Async reset mid-bubble: assert rst_n=0 between edges while ext_bubble=1 and bubble_cnt=10 → outputs go to reset values immediately, without waiting for a clk edge; bubble_cnt=0.
